// File: rtl/pll_mgmt_pkg.sv
// Shared definitions for the PLL management responder: register map, FSM states,
// C-counter field positions and the divide-value calculation.
package pll_mgmt_pkg;

  localparam logic [5:0] ADDR_MODE     = 6'h00;
  localparam logic [5:0] ADDR_STATUS   = 6'h01;
  localparam logic [5:0] ADDR_START    = 6'h02;
  localparam logic [5:0] ADDR_C_SHADOW = 6'h05;

  localparam int unsigned BYPASS_BIT = 16;
  localparam int unsigned ODD_BIT    = 17;
  localparam int unsigned DIV_W      = 9;

  localparam logic [31:0] C_48MHZ   = 32'h00000A0A;
  localparam logic [31:0] C_50P5MHZ = 32'h00020A09;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    RELOCK
  } pll_state_e;

  // A zero high/low count means 256, as in the PLL counter; result saturates.
  function automatic logic [DIV_W-1:0] c_div_calc(input logic       bypass,
                                                  input logic [7:0] hi,
                                                  input logic [7:0] lo);
    logic [9:0] hi_n;
    logic [9:0] lo_n;
    logic [9:0] sum;
    hi_n = (hi == 8'd0) ? 10'd256 : 10'(hi);
    lo_n = (lo == 8'd0) ? 10'd256 : 10'(lo);
    sum  = hi_n + lo_n;
    if (bypass) return DIV_W'(1);
    if (sum > 10'd511) return 9'h1FF;
    return sum[DIV_W-1:0];
  endfunction

endpackage

// File: rtl/pll_c_decode.sv
// Combinational decode of a C-counter word into its effective divide value.
module pll_c_decode
  import pll_mgmt_pkg::*;
(
  input  logic [31:0]      c_word,
  output logic [DIV_W-1:0] div_c
);

  // Odd-duty bit and upper bits do not change the divide value.
  logic unused_bits;
  assign unused_bits = ^c_word[31:BYPASS_BIT+1];

  assign div_c = c_div_calc(c_word[BYPASS_BIT], c_word[15:8], c_word[7:0]);

endmodule

// File: rtl/pll_mgmt_responder.sv
// Avalon-MM style management slave that models PLL C-counter reconfiguration:
// apply phase, relock phase, status and waitrequest/polling handshake.
module pll_mgmt_responder
  import pll_mgmt_pkg::*;
#(
  parameter int unsigned APPLY_CYCLES = 16,
  parameter int unsigned LOCK_CYCLES  = 64,
  parameter logic [31:0] C_RESET      = 32'h00000A0A
) (
  input  logic             clk_sys,
  input  logic             RESET_n,
  input  logic [5:0]       mgmt_address,
  input  logic             mgmt_write,
  input  logic [31:0]      mgmt_writedata,
  input  logic             mgmt_read,
  output logic [31:0]      mgmt_readdata,
  output logic             mgmt_readdatavalid,
  output logic             mgmt_waitrequest,
  output logic [31:0]      c_active,
  output logic [DIV_W-1:0] c_divisor,
  output logic             locked,
  output logic             busy
);

  localparam int unsigned CNT_MAX = (APPLY_CYCLES > LOCK_CYCLES) ? APPLY_CYCLES : LOCK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      snap_q, snap_d;
  logic [31:0]      c_active_q, c_active_d;
  logic [DIV_W-1:0] c_div_q, c_div_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             locked_q, locked_d;
  logic             wait_q, wait_d;
  logic             rdv_q, rdv_d;
  logic [31:0]      rdata_q, rdata_d;

  logic wr_acc;
  logic rd_acc;
  logic start_wr;

  assign wr_acc   = mgmt_write & ~wait_q;
  assign rd_acc   = mgmt_read & ~mgmt_write & ~wait_q;
  assign start_wr = wr_acc && (mgmt_address == ADDR_START);

  pll_c_decode u_decode (
    .c_word (c_active_d),
    .div_c  (c_div_d)
  );

  // Next-state, register-file and read-path logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    snap_d     = snap_q;
    c_active_d = c_active_q;
    mode_d     = mode_q;
    err_d      = err_q;
    rdv_d      = 1'b0;
    rdata_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (start_wr) begin
          state_d = APPLY;
          cnt_d   = '0;
          snap_d  = shadow_q;
        end
      end
      APPLY: begin
        if (cnt_q == CNT_W'(APPLY_CYCLES - 1)) begin
          state_d    = RELOCK;
          cnt_d      = '0;
          c_active_d = snap_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELOCK: begin
        if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_acc) begin
      unique case (mgmt_address)
        ADDR_MODE:     mode_d   = mgmt_writedata[0];
        ADDR_STATUS:   err_d    = 1'b0;
        ADDR_START:    if (busy_q) err_d = 1'b1;
        ADDR_C_SHADOW: shadow_d = mgmt_writedata;
        default: ;
      endcase
    end

    if (rd_acc) begin
      rdv_d = 1'b1;
      unique case (mgmt_address)
        ADDR_MODE:     rdata_d = 32'(mode_q);
        ADDR_STATUS:   rdata_d = 32'({err_q, ~busy_q});
        ADDR_C_SHADOW: rdata_d = shadow_q;
        default:       rdata_d = '0;
      endcase
    end

    busy_d   = (state_d != IDLE);
    locked_d = (state_d == IDLE);
    wait_d   = busy_d & ~mode_d;
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= RELOCK;
      cnt_q      <= '0;
      shadow_q   <= C_RESET;
      snap_q     <= C_RESET;
      c_active_q <= C_RESET;
      c_div_q    <= c_div_calc(C_RESET[BYPASS_BIT], C_RESET[15:8], C_RESET[7:0]);
      mode_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b1;
      locked_q   <= 1'b0;
      wait_q     <= 1'b1;
      rdv_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      snap_q     <= snap_d;
      c_active_q <= c_active_d;
      c_div_q    <= c_div_d;
      mode_q     <= mode_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      locked_q   <= locked_d;
      wait_q     <= wait_d;
      rdv_q      <= rdv_d;
      rdata_q    <= rdata_d;
    end
  end

  assign mgmt_readdata      = rdata_q;
  assign mgmt_readdatavalid = rdv_q;
  assign mgmt_waitrequest   = wait_q;
  assign c_active           = c_active_q;
  assign c_divisor          = c_div_q;
  assign locked             = locked_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_pll_mgmt_responder.sv
// Self-checking bench for pll_mgmt_responder: directed scenarios plus randomized
// reconfigurations checked against a register/timing model.
module tb_pll_mgmt_responder;

  localparam logic [31:0] C_RST = 32'h00000A0A;
  localparam int APPLY_N = 16;
  localparam int LOCK_N  = 64;

  logic        clk_sys = 1'b0;
  logic        RESET_n;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_read;
  logic [31:0] mgmt_readdata;
  logic        mgmt_readdatavalid;
  logic        mgmt_waitrequest;
  logic [31:0] c_active;
  logic [8:0]  c_divisor;
  logic        locked;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic        model_mode;
  logic        model_err;
  logic [31:0] model_shadow;

  always #5 clk_sys = ~clk_sys;

  pll_mgmt_responder dut (
    .clk_sys            (clk_sys),
    .RESET_n            (RESET_n),
    .mgmt_address       (mgmt_address),
    .mgmt_write         (mgmt_write),
    .mgmt_writedata     (mgmt_writedata),
    .mgmt_read          (mgmt_read),
    .mgmt_readdata      (mgmt_readdata),
    .mgmt_readdatavalid (mgmt_readdatavalid),
    .mgmt_waitrequest   (mgmt_waitrequest),
    .c_active           (c_active),
    .c_divisor          (c_divisor),
    .locked             (locked),
    .busy               (busy)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Divide value from the PLL counter rules: bypass -> 1, zero count -> 256, cap 511.
  function automatic logic [8:0] ref_div(input logic [31:0] w);
    int hi, lo, s;
    if (w[16]) return 9'd1;
    hi = int'(w[15:8]);
    lo = int'(w[7:0]);
    if (hi == 0) hi = 256;
    if (lo == 0) lo = 256;
    s = hi + lo;
    if (s > 511) s = 511;
    return 9'(s);
  endfunction

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    int n;
    n = 0;
    mgmt_address = a; mgmt_writedata = d; mgmt_write = 1'b1;
    while (mgmt_waitrequest && n < 500) begin tick(); n++; end
    if (mgmt_waitrequest) begin
      checks++; errors++;
      $display("FAIL write_timeout: addr %0h still stalled after %0d cycles", a, n);
    end
    tick();
    mgmt_write = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d,
                          output logic v1, output logic v2);
    int n;
    n = 0;
    mgmt_address = a; mgmt_read = 1'b1;
    while (mgmt_waitrequest && n < 500) begin tick(); n++; end
    if (mgmt_waitrequest) begin
      checks++; errors++;
      $display("FAIL read_timeout: addr %0h still stalled after %0d cycles", a, n);
    end
    tick();
    mgmt_read = 1'b0;
    v1 = mgmt_readdatavalid;
    d  = mgmt_readdata;
    tick();
    v2 = mgmt_readdatavalid;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 1000) begin tick(); cyc++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles", cyc);
    end
  endtask

  task automatic model_reset();
    model_mode = 1'b0; model_err = 1'b0; model_shadow = C_RST;
  endtask

  task automatic count_relock(input string tag);
    int n, bad;
    n = 0; bad = 0;
    while (!locked && n < 200) begin
      if (!busy || !mgmt_waitrequest) bad++;
      tick(); n++;
    end
    checks++;
    if (n !== LOCK_N) begin errors++; $display("FAIL %s_lock_delay: got %0d cycles, want %0d", tag, n, LOCK_N); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL %s_busy_wait: %0d cycles with busy/waitrequest low, want 0", tag, bad); end
    checks++;
    if ({busy, mgmt_waitrequest} !== 2'b00) begin
      errors++; $display("FAIL %s_after_lock: busy,wait = %b, want 00", tag, {busy, mgmt_waitrequest});
    end
  endtask

  task automatic test_reset();
    RESET_n = 1'b0; mgmt_address = '0; mgmt_write = 1'b0; mgmt_read = 1'b0; mgmt_writedata = '0;
    model_reset();
    repeat (3) tick();
    checks++;
    if ({busy, mgmt_waitrequest, locked, mgmt_readdatavalid} !== 4'b1100) begin
      errors++; $display("FAIL reset_flags: busy,wait,locked,rdv = %b, want 1100",
                         {busy, mgmt_waitrequest, locked, mgmt_readdatavalid});
    end
    checks++;
    if (mgmt_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", mgmt_readdata); end
    checks++;
    if (c_active !== C_RST) begin errors++; $display("FAIL reset_c_active: got %h want %h", c_active, C_RST); end
    RESET_n = 1'b1;
    count_relock("reset");
    checks++;
    if (c_divisor !== 9'd20) begin errors++; $display("FAIL reset_c_divisor: got %0d want 20", c_divisor); end
  endtask

  task automatic test_wait_reconfig();
    int n, lock_bad;
    bus_write(6'h05, 32'h00020A09); model_shadow = 32'h00020A09;
    bus_write(6'h02, 32'h1);
    n = 0; lock_bad = 0;
    while (mgmt_waitrequest && n < 300) begin
      if (locked) lock_bad++;
      if (n == APPLY_N - 1) begin
        checks++;
        if (c_active !== C_RST) begin errors++; $display("FAIL apply_early: c_active %h want %h", c_active, C_RST); end
      end
      if (n == APPLY_N) begin
        checks++;
        if (c_active !== 32'h00020A09) begin errors++; $display("FAIL apply_load: c_active %h want 00020a09", c_active); end
      end
      tick(); n++;
    end
    checks++;
    if (n !== APPLY_N + LOCK_N) begin errors++; $display("FAIL wait_length: got %0d cycles want %0d", n, APPLY_N + LOCK_N); end
    checks++;
    if (lock_bad !== 0) begin errors++; $display("FAIL locked_low: locked high in %0d busy cycles, want 0", lock_bad); end
    checks++;
    if ({locked, busy} !== 2'b10) begin errors++; $display("FAIL reconfig_end: locked,busy = %b want 10", {locked, busy}); end
    checks++;
    if (c_divisor !== 9'd19) begin errors++; $display("FAIL div_0a09: got %0d want 19", c_divisor); end
  endtask

  task automatic test_polling_error();
    logic [31:0] d; logic v1, v2; int cyc;
    bus_write(6'h00, 32'h1); model_mode = 1'b1;
    bus_write(6'h02, 32'h1);
    repeat (4) tick();
    checks++;
    if (mgmt_waitrequest !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL poll_wait: wait,busy = %b want 01", {mgmt_waitrequest, busy});
    end
    bus_write(6'h02, 32'h1); model_err = 1'b1;
    bus_read(6'h01, d, v1, v2);
    checks++;
    if (d !== {30'd0, model_err, 1'b0} || v1 !== 1'b1) begin
      errors++; $display("FAIL status_busy_err: got %h v=%b want 00000002 v=1", d, v1);
    end
    wait_idle(cyc);
    bus_read(6'h01, d, v1, v2);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL status_done_err: got %h want 00000003", d); end
    bus_write(6'h01, 32'h0); model_err = 1'b0;
    bus_read(6'h01, d, v1, v2);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL status_cleared: got %h want 00000001", d); end
    checks++;
    if (c_active !== model_shadow) begin errors++; $display("FAIL ignored_start: c_active %h want %h", c_active, model_shadow); end
  endtask

  task automatic test_shadow_isolation();
    logic [31:0] d; logic v1, v2; int cyc;
    bus_write(6'h05, 32'h00000A0A);
    bus_write(6'h02, 32'h1);
    repeat (2) tick();
    bus_write(6'h05, 32'h00000A09); model_shadow = 32'h00000A09;
    wait_idle(cyc);
    checks++;
    if (c_active !== 32'h00000A0A) begin errors++; $display("FAIL snapshot: c_active %h want 00000a0a", c_active); end
    bus_read(6'h05, d, v1, v2);
    checks++;
    if (d !== 32'h00000A09) begin errors++; $display("FAIL shadow_rd: got %h want 00000a09", d); end
  endtask

  task automatic test_reset_mid_apply();
    logic [31:0] d; logic v1, v2;
    bus_write(6'h05, 32'h00020A09);
    bus_write(6'h02, 32'h1);
    repeat (5) tick();
    RESET_n = 1'b0; model_reset();
    repeat (2) tick();
    checks++;
    if ({busy, mgmt_waitrequest, locked} !== 3'b110) begin
      errors++; $display("FAIL midrst_flags: busy,wait,locked = %b want 110", {busy, mgmt_waitrequest, locked});
    end
    RESET_n = 1'b1;
    count_relock("midrst");
    checks++;
    if (c_active !== C_RST) begin errors++; $display("FAIL midrst_c_active: got %h want %h", c_active, C_RST); end
    bus_read(6'h05, d, v1, v2);
    checks++;
    if (d !== C_RST) begin errors++; $display("FAIL midrst_shadow: got %h want %h", d, C_RST); end
    bus_read(6'h00, d, v1, v2);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL midrst_mode: got %h want 0", d); end
  endtask

  task automatic test_decode_unmapped();
    logic [31:0] d; logic v1, v2; int cyc;
    bus_write(6'h05, 32'h00010000); bus_write(6'h02, 32'h1); wait_idle(cyc);
    checks++;
    if (c_divisor !== 9'd1) begin errors++; $display("FAIL div_bypass: got %0d want 1", c_divisor); end
    bus_write(6'h05, 32'h00000000); bus_write(6'h02, 32'h1); wait_idle(cyc);
    model_shadow = 32'h0;
    checks++;
    if (c_divisor !== 9'h1FF) begin errors++; $display("FAIL div_zero: got %h want 1ff", c_divisor); end
    bus_write(6'h07, 32'hFFFFFFFF);
    bus_read(6'h07, d, v1, v2);
    checks++;
    if (d !== 32'h0 || v1 !== 1'b1 || v2 !== 1'b0) begin
      errors++; $display("FAIL unmapped_rd: got %h v=%b%b want 0 v=10", d, v1, v2);
    end
    bus_read(6'h02, d, v1, v2);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL start_rd: got %h want 0", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic v1, v2, p1, p2;
    mgmt_address = 6'h05; mgmt_writedata = 32'h1234ABCD; mgmt_write = 1'b1; mgmt_read = 1'b1;
    tick();
    mgmt_write = 1'b0; mgmt_read = 1'b0; model_shadow = 32'h1234ABCD;
    p1 = mgmt_readdatavalid;
    tick();
    p2 = mgmt_readdatavalid;
    checks++;
    if ({p1, p2} !== 2'b00) begin errors++; $display("FAIL rw_no_rdv: rdv = %b want 00", {p1, p2}); end
    bus_read(6'h05, d, v1, v2);
    checks++;
    if (d !== model_shadow) begin errors++; $display("FAIL rw_as_write: got %h want %h", d, model_shadow); end
  endtask

  task automatic test_random();
    logic [31:0] w, d, md; logic v1, v2; logic [5:0] ua; int cyc;
    for (int i = 0; i < 10; i++) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0: w[15:8] = 8'h00;
        1: w[7:0]  = 8'h00;
        default: ;
      endcase
      w[16] = ($urandom_range(0, 3) == 0);
      md = $urandom;
      bus_write(6'h00, md); model_mode = md[0];
      bus_write(6'h05, w);  model_shadow = w;
      bus_write(6'h02, $urandom);
      wait_idle(cyc);
      checks++;
      if (cyc !== APPLY_N + LOCK_N) begin errors++; $display("FAIL rnd%0d_busy_len: got %0d want %0d", i, cyc, APPLY_N + LOCK_N); end
      checks++;
      if (c_active !== w) begin errors++; $display("FAIL rnd%0d_c_active: got %h want %h", i, c_active, w); end
      checks++;
      if (c_divisor !== ref_div(w)) begin errors++; $display("FAIL rnd%0d_div: got %h want %h", i, c_divisor, ref_div(w)); end
      bus_read(6'h00, d, v1, v2);
      checks++;
      if (d !== {31'd0, model_mode}) begin errors++; $display("FAIL rnd%0d_mode: got %h want %h", i, d, {31'd0, model_mode}); end
      bus_read(6'h01, d, v1, v2);
      checks++;
      if (d !== {30'd0, model_err, 1'b1}) begin errors++; $display("FAIL rnd%0d_status: got %h want %h", i, d, {30'd0, model_err, 1'b1}); end
      ua = 6'($urandom_range(6, 63));
      bus_read(ua, d, v1, v2);
      checks++;
      if (d !== 32'h0 || v1 !== 1'b1) begin errors++; $display("FAIL rnd%0d_unmapped: addr %h got %h v=%b want 0 v=1", i, ua, d, v1); end
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_wait_reconfig();
    test_polling_error();
    test_shadow_isolation();
    test_reset_mid_apply();
    test_decode_unmapped();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
